// File: rtl/led_io_pkg.sv
// ----------------------------------------------------------------------------
// led_io_pkg
// Shared constants for the memory-mapped PWM LED driver.
//   CTRL_EN_BIT    : control register bit that globally enables the LEDs
//   CTRL_BLINK_BIT : control register bit that turns on hardware blinking
//   CTRL_RST_VAL   : control register value after reset (enabled, no blink)
// ----------------------------------------------------------------------------
package led_io_pkg;

    localparam int         CTRL_EN_BIT    = 0;
    localparam int         CTRL_BLINK_BIT = 1;
    localparam logic [7:0] CTRL_RST_VAL   = 8'h01;

endpackage

// File: rtl/led_pwm_ch.sv
// ----------------------------------------------------------------------------
// led_pwm_ch
// One PWM LED channel: the CPU-visible duty register, a shadow copy that is
// only refreshed at the PWM period boundary (so a period is never cut short
// or stretched by a mid-period write), and the duty/counter compare.
// Ports:
//   clk_i       system clock
//   rst_i       synchronous reset, active high
//   wr_en_i     CPU write strobe already decoded for this channel
//   wdata_i     CPU write data
//   boundary_i  one-cycle pulse on the PWM period wrap
//   pwm_cnt_i   shared PWM counter
//   gate_i      global enable and blink gating from the top level
//   duty_o      current duty register (for CPU read-back)
//   lit_o       combinational "LED should be lit" for this channel
// ----------------------------------------------------------------------------
module led_pwm_ch
    import led_io_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              boundary_i,
    input  logic [DATA_W-1:0] pwm_cnt_i,
    input  logic              gate_i,
    output logic [DATA_W-1:0] duty_o,
    output logic              lit_o
);

    logic [DATA_W-1:0] duty_q, duty_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;

    // Next-state for the duty and shadow registers. The shadow samples the
    // old duty value, so a write landing on the boundary cycle itself only
    // takes effect one period later.
    always_comb begin
        duty_d   = wr_en_i    ? wdata_i : duty_q;
        shadow_d = boundary_i ? duty_q  : shadow_q;
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            duty_q   <= '0;
            shadow_q <= '0;
        end else begin
            duty_q   <= duty_d;
            shadow_q <= shadow_d;
        end
    end

    // The counter never exceeds 2**DATA_W-2, so a full-scale duty is always on
    // and a zero duty is always off.
    assign duty_o = duty_q;
    assign lit_o  = gate_i & (shadow_q > pwm_cnt_i);

endmodule

// File: rtl/led_pwm_io.sv
// ----------------------------------------------------------------------------
// led_pwm_io
// Memory-mapped multi-channel PWM LED driver. It snoops the CPU RAM write bus,
// keeps one duty register per channel plus a control register (enable and
// blink), and lets the CPU read every register back.
// Ports:
//   clk        system clock
//   rst        synchronous reset, active high
//   ram_wadr   snooped write address
//   ram_wdata  snooped write data
//   ram_wen    snooped write enable
//   ram_radr   read address
//   io_rsel    read address hits CTRL or a channel (combinational)
//   io_rdata   read data, zero when io_rsel is low (combinational)
//   led        registered LED pins, polarity set by ACTIVE_LOW
// Map: CTRL at BASE_ADR-1, channel i at BASE_ADR+i.
// ----------------------------------------------------------------------------
module led_pwm_io
    import led_io_pkg::*;
#(
    parameter int NUM_CH        = 3,
    parameter int ADR_W         = 8,
    parameter int DATA_W        = 8,
    parameter int BASE_ADR      = 'hFD,
    parameter int PRESCALE      = 4,
    parameter int BLINK_PERIODS = 64,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADR_W-1:0]  ram_wadr,
    input  logic [DATA_W-1:0] ram_wdata,
    input  logic              ram_wen,
    input  logic [ADR_W-1:0]  ram_radr,
    output logic              io_rsel,
    output logic [DATA_W-1:0] io_rdata,
    output logic [NUM_CH-1:0] led
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BP_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;

    localparam logic [PS_W-1:0]   PS_MAX   = PS_W'(PRESCALE - 1);
    localparam logic [BP_W-1:0]   BP_MAX   = BP_W'(BLINK_PERIODS - 1);
    localparam logic [DATA_W-1:0] CNT_MAX  = DATA_W'((2 ** DATA_W) - 2);
    localparam logic [ADR_W-1:0]  CTRL_ADR = ADR_W'(BASE_ADR - 1);

    if (BASE_ADR < 1 || (BASE_ADR + NUM_CH - 1) > ((2 ** ADR_W) - 1)) begin : g_bad_cfg
        $error("led_pwm_io: register window does not fit the address space");
    end

    logic [PS_W-1:0]   prescale_q, prescale_d;
    logic [DATA_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [BP_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic              phase_q, phase_d;
    logic [DATA_W-1:0] ctrl_q, ctrl_d;
    logic [NUM_CH-1:0] led_q, led_d;

    logic              tick;
    logic              boundary;
    logic              gate;
    logic [NUM_CH-1:0] lit;
    logic [DATA_W-1:0] duty [NUM_CH];

    // Timebase: prescaler produces ticks, the PWM counter advances on ticks
    // and its wrap marks the period boundary. Blink counts boundaries only
    // while BLINK is set; clearing BLINK parks it lit-phase-first.
    always_comb begin
        tick        = (prescale_q == PS_MAX);
        boundary    = tick && (pwm_cnt_q == CNT_MAX);
        prescale_d  = tick ? '0 : prescale_q + PS_W'(1);
        pwm_cnt_d   = pwm_cnt_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (tick) begin
            pwm_cnt_d = boundary ? '0 : pwm_cnt_q + DATA_W'(1);
        end
        if (!ctrl_q[CTRL_BLINK_BIT]) begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (boundary) begin
            if (blink_cnt_q == BP_MAX) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BP_W'(1);
            end
        end
        ctrl_d = (ram_wen && ram_wadr == CTRL_ADR) ? ram_wdata : ctrl_q;
        gate   = ctrl_q[CTRL_EN_BIT] & (~ctrl_q[CTRL_BLINK_BIT] | phase_q);
        led_d  = lit ^ {NUM_CH{ACTIVE_LOW}};
    end

    // All top-level state, synchronous reset to LEDs off and CTRL enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescale_q  <= '0;
            pwm_cnt_q   <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            ctrl_q      <= DATA_W'(CTRL_RST_VAL);
            led_q       <= {NUM_CH{ACTIVE_LOW}};
        end else begin
            prescale_q  <= prescale_d;
            pwm_cnt_q   <= pwm_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            ctrl_q      <= ctrl_d;
            led_q       <= led_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wrHit;
        assign wrHit = ram_wen && (ram_wadr == ADR_W'(BASE_ADR + i));

        led_pwm_ch #(
            .DATA_W (DATA_W)
        ) u_ch (
            .clk_i      (clk),
            .rst_i      (rst),
            .wr_en_i    (wrHit),
            .wdata_i    (ram_wdata),
            .boundary_i (boundary),
            .pwm_cnt_i  (pwm_cnt_q),
            .gate_i     (gate),
            .duty_o     (duty[i]),
            .lit_o      (lit[i])
        );
    end

    // Read-back mux: duty registers (not shadows) and CTRL, no side effects.
    always_comb begin
        io_rsel  = 1'b0;
        io_rdata = '0;
        if (ram_radr == CTRL_ADR) begin
            io_rsel  = 1'b1;
            io_rdata = ctrl_q;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (ram_radr == ADR_W'(BASE_ADR + i)) begin
                io_rsel  = 1'b1;
                io_rdata = duty[i];
            end
        end
    end

    assign led = led_q;

endmodule
